delay_line: RTL and testbench

Parametrised signed delay line with a runtime-selectable tap, clock enable, synchronous flush and a priming indicator. Successor to the fixed-depth pipeline delays in the datapath; used to align samples between filter branches whose latencies differ or change by mode. With `ce` held high and `delay_sel = 6`, it behaves exactly like a fixed six-stage registered delay.

---
 rtl/delay_pkg.sv | 18 +
 rtl/delay_tap_mux.sv | 22 ++
 rtl/delay_line.sv | 97 +++++++++
 tb/tb_delay_line.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared defaults and the tap-clamping helper for the delay_line block.
package delay_pkg;

    localparam int DELAY_DEFAULT_WIDTH     = 25;
    localparam int DELAY_DEFAULT_MAX_DEPTH = 16;

    typedef logic signed [DELAY_DEFAULT_WIDTH-1:0] sample_t;

    // Requested delay of 0 still means one register; anything past the end reads the last stage.
    function automatic int clamp_delay(input int sel, input int max_depth);
        if (sel < 1)
            return 1;
        else if (sel > max_depth)
            return max_depth;
        return sel;
    endfunction

endpackage

// File: rtl/delay_tap_mux.sv
// Read mux selecting stage[tap-1] from a flattened stage vector; tap is 1-based.
module delay_tap_mux
    import delay_pkg::*;
#(
    parameter int WIDTH     = DELAY_DEFAULT_WIDTH,
    parameter int MAX_DEPTH = DELAY_DEFAULT_MAX_DEPTH,
    parameter int SEL_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic [MAX_DEPTH*WIDTH-1:0] stages,
    input  logic [SEL_W-1:0]           tap,
    output logic [WIDTH-1:0]           data
);

    always_comb begin
        data = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (tap == SEL_W'(i + 1))
                data = stages[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/delay_line.sv
// Signed delay line with runtime tap select, clock enable, flush and priming flag.
// Optional parallel valid storage is enabled with DELAY_LINE_VALID_EN.
module delay_line
    import delay_pkg::*;
#(
    parameter int WIDTH     = DELAY_DEFAULT_WIDTH,
    parameter int MAX_DEPTH = DELAY_DEFAULT_MAX_DEPTH,
    parameter int SEL_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             flush,
    input  logic [SEL_W-1:0] delay_sel,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             primed
);

    localparam logic [SEL_W-1:0] FILL_MAX = SEL_W'(MAX_DEPTH);

    logic [MAX_DEPTH-1:0][WIDTH-1:0] stage;
    logic [SEL_W-1:0]                d_eff;
    logic [SEL_W-1:0]                tap_q;
    logic [SEL_W-1:0]                fill;
    logic                            tap_chg;

    assign d_eff   = SEL_W'(clamp_delay(int'(delay_sel), MAX_DEPTH));
    assign tap_chg = (d_eff != tap_q);
    assign primed  = (fill >= d_eff);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stage <= '0;
        else if (flush)
            stage <= '0;
        else if (ce)
            stage <= {stage[MAX_DEPTH-2:0], data_in};
    end

    // A tap change restarts priming but keeps the stored samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tap_q <= SEL_W'(1);
            fill  <= '0;
        end else begin
            tap_q <= d_eff;
            if (flush || tap_chg)
                fill <= '0;
            else if (ce && fill != FILL_MAX)
                fill <= fill + SEL_W'(1);
        end
    end

    delay_tap_mux #(
        .WIDTH     (WIDTH),
        .MAX_DEPTH (MAX_DEPTH),
        .SEL_W     (SEL_W)
    ) u_data_mux (
        .stages (stage),
        .tap    (d_eff),
        .data   (data_out)
    );

`ifdef DELAY_LINE_VALID_EN
    logic [MAX_DEPTH-1:0] vstage;
    logic                 vtap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vstage <= '0;
        else if (flush)
            vstage <= '0;
        else if (ce)
            vstage <= {vstage[MAX_DEPTH-2:0], in_valid};
    end

    delay_tap_mux #(
        .WIDTH     (1),
        .MAX_DEPTH (MAX_DEPTH),
        .SEL_W     (SEL_W)
    ) u_valid_mux (
        .stages (vstage),
        .tap    (d_eff),
        .data   (vtap)
    );

    assign out_valid = vtap & primed;
`else
    logic unused_in_valid;
    assign unused_in_valid = in_valid;
    assign out_valid       = primed;
`endif

endmodule

// File: tb/tb_delay_line.sv
// Self-checking bench for delay_line: directed tables/sequences plus random stimulus vs a queue model.
module tb_delay_line;

    localparam int WIDTH     = 25;
    localparam int MAX_DEPTH = 16;
    localparam int SEL_W     = $clog2(MAX_DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             ce;
    logic             flush;
    logic [SEL_W-1:0] delay_sel;
    logic [WIDTH-1:0] data_in;
    logic             in_valid;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             primed;

    int checks   = 0;
    int failures = 0;

    delay_line #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .flush     (flush),
        .delay_sel (delay_sel),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .data_out  (data_out),
        .out_valid (out_valid),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    // Reference model: newest accepted sample at the front of the queue.
    logic [WIDTH-1:0] mq[$];
    bit               mv[$];
    int               mcnt;
    int               mlast;

    function automatic int clampf(input int s);
        return (s < 1) ? 1 : (s > MAX_DEPTH) ? MAX_DEPTH : s;
    endfunction

    task automatic model_reset();
        mq.delete();
        mv.delete();
        for (int i = 0; i < MAX_DEPTH; i++) begin
            mq.push_back('0);
            mv.push_back(1'b0);
        end
        mcnt  = 0;
        mlast = 1;
    endtask

    task automatic model_edge();
        int d;
        d = clampf(int'(delay_sel));
        if (flush) begin
            model_reset();
        end else begin
            if (ce) begin
                mq.push_front(data_in);
                void'(mq.pop_back());
                mv.push_front(in_valid);
                void'(mv.pop_back());
            end
            if (d != mlast)
                mcnt = 0;
            else if (ce && mcnt < MAX_DEPTH)
                mcnt++;
        end
        mlast = d;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int d;
        int ep;
        int ev;
        d  = clampf(int'(delay_sel));
        ep = (mcnt >= d) ? 1 : 0;
`ifdef DELAY_LINE_VALID_EN
        ev = (mv[d-1] && ep == 1) ? 1 : 0;
`else
        ev = ep;
`endif
        chk({tag, "_data"},   $signed(data_out), $signed(mq[d-1]));
        chk({tag, "_primed"}, int'(primed),      ep);
        chk({tag, "_valid"},  int'(out_valid),   ev);
    endtask

    task automatic step(input bit c, input bit f, input int sel, input int din, input bit iv, input string tag);
        ce        = c;
        flush     = f;
        delay_sel = SEL_W'(sel);
        data_in   = WIDTH'(din);
        in_valid  = iv;
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        ce = 0; flush = 0; in_valid = 0; data_in = '0;
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("rst_data",   $signed(data_out), 0);
        chk("rst_primed", int'(primed),      0);
        chk("rst_valid",  int'(out_valid),   0);
    endtask

    typedef struct {
        bit ce;
        int din;
        int exp_data;
        bit exp_primed;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int n;
        int low;
        int v;
        bit iv_pat[5];

        reset = 1'b1; ce = 0; flush = 0; in_valid = 0; data_in = '0; delay_sel = SEL_W'(1);
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("init_data",   $signed(data_out), 0);
        chk("init_primed", int'(primed),      0);

        // Ramp at D=6: the settle cycle absorbs the tap change so priming aligns with the data.
        for (int k = 1; k <= 12; k++) begin
            tbl[k-1].ce         = 1'b1;
            tbl[k-1].din        = k;
            tbl[k-1].exp_data   = (k >= 6) ? k - 5 : 0;
            tbl[k-1].exp_primed = (k >= 6);
        end
        do_reset();
        step(0, 0, 6, 0, 0, "settle6");
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].ce, 0, 6, tbl[i].din, 1, "ramp");
            chk("tbl_data",   $signed(data_out), tbl[i].exp_data);
            chk("tbl_primed", int'(primed),      int'(tbl[i].exp_primed));
        end

        // ce alternating at D=4 with negative samples.
        do_reset();
        step(0, 0, 4, 0, 0, "settle4");
        n = 0; v = -5;
        for (int c = 1; c <= 14; c++) begin
            if (c % 2 == 1) begin
                step(1, 0, 4, v, 1, "cepat");
                n++; v--;
            end else begin
                step(0, 0, 4, 12345, 1, "cepat");
            end
            chk("ce_hold", $signed(data_out), (n >= 4) ? -5 - (n - 4) : 0);
        end

        // Tap change from 8 to 3 while primed.
        do_reset();
        step(0, 0, 8, 0, 0, "settle8");
        for (int k = 1; k <= 12; k++) step(1, 0, 8, 100 + k, 1, "tap8");
        delay_sel = SEL_W'(3);
        #1;
        chk("tap_imm_data",   $signed(data_out), 110);
        chk("tap_imm_primed", int'(primed),      1);
        low = 0;
        for (int j = 0; j < 10; j++) begin
            step(1, 0, 3, 113 + j, 1, "tap3");
            if (primed) break;
            low++;
        end
        chk("tap_low_cycles", low, 3);

        // Flush with ce=1 on sample 10 at D=5.
        do_reset();
        step(0, 0, 5, 0, 0, "settle5");
        for (int k = 1; k <= 9; k++) step(1, 0, 5, k, 1, "prefl");
        step(1, 1, 5, 10, 1, "flush");
        chk("flush_data",   $signed(data_out), 0);
        chk("flush_primed", int'(primed),      0);
        for (int k = 11; k <= 20; k++) begin
            step(1, 0, 5, k, 1, "postfl");
            chk("flush_seq",    $signed(data_out), (k >= 15) ? k - 4 : 0);
            chk("flush_primed", int'(primed),      (k >= 15) ? 1 : 0);
        end

        // Clamp boundaries: 0 behaves as 1, 31 behaves as 16.
        do_reset();
        step(0, 0, 0, 0, 0, "settle0");
        step(1, 0, 0, 77, 1, "lat1");
        chk("lat1_data",   $signed(data_out), 77);
        chk("lat1_primed", int'(primed),      1);
        do_reset();
        step(0, 0, 31, 0, 0, "settle31");
        step(1, 0, 31, 55, 1, "lat16");
        for (int j = 1; j <= 15; j++) begin
            step(1, 0, 31, 0, 1, "lat16");
            chk("lat16_data", $signed(data_out), (j == 15) ? 55 : 0);
        end

        // Asynchronous reset between edges.
        #2 reset = 1'b1;
        #1;
        chk("arst_data",   $signed(data_out), 0);
        chk("arst_primed", int'(primed),      0);
        chk("arst_valid",  int'(out_valid),   0);
        #2 reset = 1'b0;
        model_reset();

        // Valid pattern 1,0,1 at D=2.
        iv_pat = '{1, 0, 1, 0, 0};
        do_reset();
        step(0, 0, 2, 0, 0, "settle2");
        for (int k = 1; k <= 5; k++) begin
            step(1, 0, 2, k * 3, iv_pat[k-1], "vpat");
`ifdef DELAY_LINE_VALID_EN
            chk("vpat_valid", int'(out_valid), (k >= 2) ? int'(iv_pat[k-2]) : 0);
`else
            chk("vpat_valid", int'(out_valid), (k >= 2) ? 1 : 0);
`endif
        end

        // Random traffic against the model.
        do_reset();
        begin
            int sel;
            sel = 6;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 19) == 0) sel = $urandom_range(0, 31);
                step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, sel,
                     int'($urandom), $urandom_range(0, 1) == 1, "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
